// File: rtl/output_vc_credit_tracker_pkg.sv
// rtl/output_vc_credit_tracker_pkg.sv - NoC sizing, flit labels and VC state encoding
package output_vc_credit_tracker_pkg;

    localparam int VC_Size = 2;
    localparam int VC_NUM  = 2**VC_Size;

    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_Label;

    typedef enum logic [1:0] {FREE = 2'd0, ACTIVE = 2'd1, DRAINING = 2'd2} vc_state_t;

    function automatic logic is_head(input flit_Label l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_Label l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/output_vc_credit_tracker_rr_free_picker.sv
// rtl/output_vc_credit_tracker_rr_free_picker.sv - round-robin first-free search starting at ptr_i
module rr_free_picker #(
    parameter int W = 2
) (
    input  logic [2**W-1:0] free_i,
    input  logic [W-1:0]    ptr_i,
    output logic            valid_o,
    output logic [W-1:0]    idx_o
);

    localparam int N = 2**W;

    logic [W-1:0] cand;

    // W-bit candidate arithmetic gives the modulo-N wrap for free
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_i + W'(i);
            if (!valid_o && free_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/output_vc_credit_tracker.sv
// rtl/output_vc_credit_tracker.sv - per-output-port downstream VC state, credits and grant logic
module output_vc_credit_tracker
    import output_vc_credit_tracker_pkg::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req_i,
    output logic               alloc_gnt_o,
    output logic [VC_Size-1:0] alloc_vc_o,
    input  logic               flit_send_i,
    input  logic [VC_Size-1:0] flit_vc_i,
    input  flit_Label          flit_label_i,
    input  logic               credit_i,
    input  logic [VC_Size-1:0] credit_vc_i,
    input  logic               release_i,
    input  logic [VC_Size-1:0] release_vc_i,
    output logic [VC_NUM-1:0]  credit_avail_o,
    output logic [VC_NUM-1:0]  vc_free_o,
    output logic               err_o
);

    localparam int            CW   = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0] CMAX = CW'(BUFFER_SIZE);

    vc_state_t          state_q [VC_NUM];
    vc_state_t          state_d [VC_NUM];
    logic [CW-1:0]      cred_q  [VC_NUM];
    logic [CW-1:0]      cred_d  [VC_NUM];
    logic [VC_NUM-1:0]  first_q, first_d;
    logic [VC_Size-1:0] rr_ptr_q, rr_ptr_d;
    logic               err_q, err_d;

    logic [VC_NUM-1:0]  free_vec;
    logic [VC_NUM-1:0]  send_hit, cred_hit, rel_hit, send_ok;
    logic               pick_valid;
    logic [VC_Size-1:0] pick_idx;

    rr_free_picker #(.W(VC_Size)) u_picker (
        .free_i  (free_vec),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign alloc_gnt_o = alloc_req_i && pick_valid && !rst;
    assign alloc_vc_o  = pick_idx;
    assign vc_free_o   = free_vec;
    assign err_o       = err_q;

    // A send into an empty buffer is still legal when a credit lands in the same cycle
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            send_hit[v]       = flit_send_i && (flit_vc_i == VC_Size'(v));
            cred_hit[v]       = credit_i && (credit_vc_i == VC_Size'(v));
            rel_hit[v]        = release_i && (release_vc_i == VC_Size'(v));
            free_vec[v]       = (state_q[v] == FREE);
            credit_avail_o[v] = (state_q[v] == ACTIVE) && (cred_q[v] != '0);
            send_ok[v]        = send_hit[v] && (state_q[v] == ACTIVE) &&
                                ((cred_q[v] != '0) || cred_hit[v]);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        err_d    = 1'b0;
        first_d  = first_q;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            cred_d[v]  = cred_q[v];
        end

        for (int v = 0; v < VC_NUM; v++) begin
            if (send_hit[v]) begin
                if (!send_ok[v]) begin
                    err_d = 1'b1;
                end else begin
                    if (first_q[v] != is_head(flit_label_i))
                        err_d = 1'b1;
                    first_d[v] = 1'b0;
                    if (is_tail(flit_label_i))
                        state_d[v] = DRAINING;
                end
            end

            if (send_ok[v] && !cred_hit[v]) begin
                cred_d[v] = cred_q[v] - CW'(1);
            end else if (cred_hit[v] && !send_ok[v]) begin
                if (cred_q[v] == CMAX)
                    err_d = 1'b1;
                else
                    cred_d[v] = cred_q[v] + CW'(1);
            end

            // Release frees the VC even when credits went missing downstream
            if (rel_hit[v]) begin
                if (state_q[v] != DRAINING) begin
                    err_d = 1'b1;
                end else begin
                    state_d[v] = FREE;
                    cred_d[v]  = CMAX;
                    if (cred_q[v] != CMAX)
                        err_d = 1'b1;
                end
            end
        end

        if (alloc_gnt_o) begin
            state_d[pick_idx] = ACTIVE;
            first_d[pick_idx] = 1'b1;
            rr_ptr_d          = pick_idx + VC_Size'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= FREE;
                cred_q[v]  <= CMAX;
            end
            first_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
                cred_q[v]  <= cred_d[v];
            end
            first_q  <= first_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_output_vc_credit_tracker.sv
// tb/tb_output_vc_credit_tracker.sv - scoreboard bench for output_vc_credit_tracker
module tb_output_vc_credit_tracker;
    import output_vc_credit_tracker_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc_req;
    logic               alloc_gnt;
    logic [VC_Size-1:0] alloc_vc;
    logic               flit_send;
    logic [VC_Size-1:0] flit_vc;
    flit_Label          flit_label;
    logic               credit;
    logic [VC_Size-1:0] credit_vc;
    logic               rel;
    logic [VC_Size-1:0] rel_vc;
    logic [VC_NUM-1:0]  credit_avail;
    logic [VC_NUM-1:0]  vc_free;
    logic               err;

    int checks   = 0;
    int failures = 0;
    int gnt_q[$];
    bit err_q[$];

    output_vc_credit_tracker #(.BUFFER_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req_i    (alloc_req),
        .alloc_gnt_o    (alloc_gnt),
        .alloc_vc_o     (alloc_vc),
        .flit_send_i    (flit_send),
        .flit_vc_i      (flit_vc),
        .flit_label_i   (flit_label),
        .credit_i       (credit),
        .credit_vc_i    (credit_vc),
        .release_i      (rel),
        .release_vc_i   (rel_vc),
        .credit_avail_o (credit_avail),
        .vc_free_o      (vc_free),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        alloc_req = 1'b0; flit_send = 1'b0; flit_vc = '0; flit_label = BODY;
        credit = 1'b0; credit_vc = '0; rel = 1'b0; rel_vc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input int sv, input flit_Label sl,
                         input bit c, input int cv, input bit l, input int lv, input bit exp_err);
        flit_send = s; flit_vc = VC_Size'(sv); flit_label = sl;
        credit = c; credit_vc = VC_Size'(cv); rel = l; rel_vc = VC_Size'(lv);
        err_q.push_back(exp_err);
        tick();
        flit_send = 1'b0; credit = 1'b0; rel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        alloc_req = 1'b1;
        #3;
        checks += 4;
        if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%0b exp=0", alloc_gnt); end
        if (vc_free !== 4'hF) begin failures++; $display("FAIL reset_free got=%b exp=1111", vc_free); end
        if (credit_avail !== 4'h0) begin failures++; $display("FAIL reset_avail got=%b exp=0000", credit_avail); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        tick();
        rst = 1'b0;
        alloc_req = 1'b0;
        tick();
    endtask

    task automatic test_grant_order();
        bit e;
        int x;
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back(i);
            alloc_req = 1'b1;
            err_q.push_back(1'b0);
            #1;
            checks += 2;
            if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL grant%0d_gnt got=%0b exp=1", i, alloc_gnt); end
            x = gnt_q.pop_front();
            if (alloc_vc !== VC_Size'(x)) begin failures++; $display("FAIL grant%0d_vc got=%0d exp=%0d", i, alloc_vc, x); end
            tick();
            e = err_q.pop_front();
            checks++;
            if (err !== e) begin failures++; $display("FAIL grant%0d_err got=%0b exp=%0b", i, err, e); end
        end
        err_q.push_back(1'b0);
        #1;
        checks += 3;
        if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL grant_none_gnt got=%0b exp=0", alloc_gnt); end
        if (alloc_vc !== '0) begin failures++; $display("FAIL grant_none_vc got=%0d exp=0", alloc_vc); end
        if (vc_free !== 4'h0) begin failures++; $display("FAIL grant_all_free got=%b exp=0000", vc_free); end
        tick();
        alloc_req = 1'b0;
        e = err_q.pop_front();
        checks++;
        if (err !== e) begin failures++; $display("FAIL grant_none_err got=%0b exp=%0b", err, e); end
    endtask

    task automatic test_exhaust();
        bit e;
        for (int i = 0; i < 8; i++) begin
            pulse(1, 0, (i == 0) ? HEAD : BODY, 0, 0, 0, 0, 0);
            e = err_q.pop_front();
            checks++;
            if (err !== e) begin failures++; $display("FAIL exhaust_send%0d_err got=%0b exp=%0b", i, err, e); end
        end
        checks++;
        if (credit_avail !== 4'b1110) begin failures++; $display("FAIL exhaust_avail got=%b exp=1110", credit_avail); end
        pulse(1, 0, BODY, 0, 0, 0, 0, 1);
        e = err_q.pop_front();
        checks += 2;
        if (err !== e) begin failures++; $display("FAIL exhaust_over_err got=%0b exp=%0b", err, e); end
        if (credit_avail !== 4'b1110) begin failures++; $display("FAIL exhaust_over_avail got=%b exp=1110", credit_avail); end
        pulse(0, 0, BODY, 1, 0, 0, 0, 0);
        e = err_q.pop_front();
        checks += 2;
        if (err !== e) begin failures++; $display("FAIL exhaust_credit_err got=%0b exp=%0b", err, e); end
        if (credit_avail !== 4'b1111) begin failures++; $display("FAIL exhaust_credit_avail got=%b exp=1111", credit_avail); end
    endtask

    task automatic test_drain_release();
        bit e;
        int x;
        pulse(1, 1, HEADTAIL, 0, 0, 0, 0, 0);
        e = err_q.pop_front();
        checks += 3;
        if (err !== e) begin failures++; $display("FAIL drain_ht_err got=%0b exp=%0b", err, e); end
        if (credit_avail !== 4'b1101) begin failures++; $display("FAIL drain_avail got=%b exp=1101", credit_avail); end
        if (vc_free !== 4'b0000) begin failures++; $display("FAIL drain_free got=%b exp=0000", vc_free); end
        pulse(0, 0, BODY, 1, 1, 0, 0, 0);
        e = err_q.pop_front();
        checks += 2;
        if (err !== e) begin failures++; $display("FAIL drain_credit_err got=%0b exp=%0b", err, e); end
        if (credit_avail !== 4'b1101) begin failures++; $display("FAIL drain_credit_avail got=%b exp=1101", credit_avail); end
        alloc_req = 1'b1; rel = 1'b1; rel_vc = VC_Size'(1);
        err_q.push_back(1'b0);
        #1;
        checks++;
        if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL release_same_cycle_gnt got=%0b exp=0", alloc_gnt); end
        tick();
        rel = 1'b0;
        e = err_q.pop_front();
        checks += 2;
        if (err !== e) begin failures++; $display("FAIL release_err got=%0b exp=%0b", err, e); end
        if (vc_free !== 4'b0010) begin failures++; $display("FAIL release_free got=%b exp=0010", vc_free); end
        gnt_q.push_back(1);
        #1;
        x = gnt_q.pop_front();
        checks += 2;
        if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL regrant_gnt got=%0b exp=1", alloc_gnt); end
        if (alloc_vc !== VC_Size'(x)) begin failures++; $display("FAIL regrant_vc got=%0d exp=%0d", alloc_vc, x); end
        tick();
        alloc_req = 1'b0;
        checks++;
        if (vc_free !== 4'b0000) begin failures++; $display("FAIL regrant_free got=%b exp=0000", vc_free); end
    endtask

    task automatic test_same_cycle();
        bit e;
        int x;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) pulse(0, 0, BODY, 1, 0, 0, 0, 0);
            else       pulse(1, 0, BODY, 1, 0, 0, 0, 0);
            e = err_q.pop_front();
            checks++;
            if (err !== e) begin failures++; $display("FAIL same_setup%0d_err got=%0b exp=%0b", i, err, e); end
        end
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, BODY, 0, 0, 0, 0, (i == 3));
            e = err_q.pop_front();
            checks++;
            if (err !== e) begin failures++; $display("FAIL same_drain%0d_err got=%0b exp=%0b", i, err, e); end
        end
        pulse(1, 2, HEADTAIL, 0, 0, 0, 0, 0);
        void'(err_q.pop_front());
        pulse(0, 0, BODY, 1, 2, 0, 0, 0);
        void'(err_q.pop_front());
        pulse(0, 0, BODY, 0, 0, 1, 2, 0);
        e = err_q.pop_front();
        checks += 2;
        if (err !== e) begin failures++; $display("FAIL free2_release_err got=%0b exp=%0b", err, e); end
        if (vc_free !== 4'b0100) begin failures++; $display("FAIL free2_free got=%b exp=0100", vc_free); end
        pulse(0, 0, BODY, 1, 2, 0, 0, 1);
        e = err_q.pop_front();
        checks++;
        if (err !== e) begin failures++; $display("FAIL free2_sat_err got=%0b exp=%0b", err, e); end
        alloc_req = 1'b1;
        gnt_q.push_back(2);
        #1;
        x = gnt_q.pop_front();
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_vc !== VC_Size'(x)) begin
            failures++; $display("FAIL grant2 got=%0b/%0d exp=1/%0d", alloc_gnt, alloc_vc, x);
        end
        tick();
        alloc_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse(1, 2, (i == 0) ? HEAD : BODY, 0, 0, 0, 0, 0);
            e = err_q.pop_front();
            checks++;
            if (err !== e) begin failures++; $display("FAIL vc2_send%0d_err got=%0b exp=%0b", i, err, e); end
        end
        checks++;
        if (credit_avail !== 4'b1010) begin failures++; $display("FAIL vc2_sat_avail got=%b exp=1010", credit_avail); end
    endtask

    task automatic test_protocol_errors();
        bit e;
        pulse(0, 0, BODY, 0, 0, 1, 3, 1);
        e = err_q.pop_front();
        checks += 3;
        if (err !== e) begin failures++; $display("FAIL rel_active_err got=%0b exp=%0b", err, e); end
        if (vc_free !== 4'b0000) begin failures++; $display("FAIL rel_active_free got=%b exp=0000", vc_free); end
        if (credit_avail !== 4'b1010) begin failures++; $display("FAIL rel_active_avail got=%b exp=1010", credit_avail); end
        pulse(1, 3, BODY, 0, 0, 0, 0, 1);
        e = err_q.pop_front();
        checks += 2;
        if (err !== e) begin failures++; $display("FAIL first_body_err got=%0b exp=%0b", err, e); end
        if (credit_avail !== 4'b1010) begin failures++; $display("FAIL first_body_avail got=%b exp=1010", credit_avail); end
        pulse(1, 3, HEAD, 0, 0, 0, 0, 1);
        e = err_q.pop_front();
        checks++;
        if (err !== e) begin failures++; $display("FAIL late_head_err got=%0b exp=%0b", err, e); end
        pulse(0, 0, BODY, 0, 0, 0, 0, 0);
        e = err_q.pop_front();
        checks++;
        if (err !== e) begin failures++; $display("FAIL err_pulse_width got=%0b exp=%0b", err, e); end
    endtask

    task automatic test_simultaneous();
        bit e;
        pulse(1, 3, TAIL, 1, 0, 0, 0, 0);
        e = err_q.pop_front();
        checks += 3;
        if (err !== e) begin failures++; $display("FAIL simul_err got=%0b exp=%0b", err, e); end
        if (credit_avail !== 4'b0011) begin failures++; $display("FAIL simul_avail got=%b exp=0011", credit_avail); end
        if (vc_free !== 4'b0000) begin failures++; $display("FAIL simul_free got=%b exp=0000", vc_free); end
    endtask

    task automatic test_reset_mid();
        bit e;
        int x;
        pulse(0, 0, BODY, 1, 0, 0, 0, 0);
        void'(err_q.pop_front());
        pulse(1, 2, BODY, 0, 0, 0, 0, 1);
        e = err_q.pop_front();
        checks++;
        if (err !== e) begin failures++; $display("FAIL premid_err got=%0b exp=%0b", err, e); end
        #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%0b exp=0", err); end
        if (vc_free !== 4'hF) begin failures++; $display("FAIL mid_rst_free got=%b exp=1111", vc_free); end
        if (credit_avail !== 4'h0) begin failures++; $display("FAIL mid_rst_avail got=%b exp=0000", credit_avail); end
        tick();
        rst = 1'b0;
        alloc_req = 1'b1;
        gnt_q.push_back(0);
        #1;
        x = gnt_q.pop_front();
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_vc !== VC_Size'(x)) begin
            failures++; $display("FAIL mid_rst_grant got=%0b/%0d exp=1/%0d", alloc_gnt, alloc_vc, x);
        end
        tick();
        alloc_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse(1, 0, (i == 0) ? HEAD : BODY, 0, 0, 0, 0, 0);
            e = err_q.pop_front();
            checks++;
            if (err !== e) begin failures++; $display("FAIL mid_rst_send%0d_err got=%0b exp=%0b", i, err, e); end
        end
        checks++;
        if (credit_avail !== 4'b0000) begin failures++; $display("FAIL mid_rst_credit got=%b exp=0000", credit_avail); end
    endtask

    initial begin
        test_reset();
        test_grant_order();
        test_exhaust();
        test_drain_release();
        test_same_cycle();
        test_protocol_errors();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
